// File: rtl/exe_stage.sv
// exe_stage: execute stage fed by the ID/EXE register.
// It selects forwarded operands, computes single-cycle ALU results and writes
// the result plus the MEM/WB control into the EXE/MEM output bank.
//
// Optional feature, macro EXE_MULDIV_EN:
//   defined   - iterative MUL/DIVU/REMU unit, one step per cycle; stall holds upstream.
//   undefined - commands 11-13 act as NOP and stall is tied low.
//
// Ports:
//   clk, rst (async, active-low)
//   exe_cmd, val1, val2, st_value, dest_in,
//   mem_r_en_in, mem_w_en_in, wb_en_in       - ID/EXE bundle
//   fwd_sel1, fwd_sel2, fwd_sel_st           - 1=mem_fwd_val, 2=wb_fwd_val, else own value
//   mem_fwd_val, wb_fwd_val                  - forwarding sources
//   flush                                    - kill the current instruction
//   stall                                    - combinational upstream hold
//   alu_res, st_val_out, dest_out,
//   mem_r_en, mem_w_en, wb_en                - registered EXE/MEM bank
module exe_stage #(
   parameter int unsigned WORD_LEN          = 32,
   parameter int unsigned EXE_CMD_LEN       = 4,
   parameter int unsigned REG_FILE_ADDR_LEN = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [EXE_CMD_LEN-1:0]       exe_cmd,
   input  logic [WORD_LEN-1:0]          val1,
   input  logic [WORD_LEN-1:0]          val2,
   input  logic [WORD_LEN-1:0]          st_value,
   input  logic [REG_FILE_ADDR_LEN-1:0] dest_in,
   input  logic                         mem_r_en_in,
   input  logic                         mem_w_en_in,
   input  logic                         wb_en_in,
   input  logic [1:0]                   fwd_sel1,
   input  logic [1:0]                   fwd_sel2,
   input  logic [1:0]                   fwd_sel_st,
   input  logic [WORD_LEN-1:0]          mem_fwd_val,
   input  logic [WORD_LEN-1:0]          wb_fwd_val,
   input  logic                         flush,
   output logic                         stall,
   output logic [WORD_LEN-1:0]          alu_res,
   output logic [WORD_LEN-1:0]          st_val_out,
   output logic [REG_FILE_ADDR_LEN-1:0] dest_out,
   output logic                         mem_r_en,
   output logic                         mem_w_en,
   output logic                         wb_en
);

   localparam int unsigned SHAMT_W = 5;

   localparam logic [EXE_CMD_LEN-1:0] CMD_NOP = EXE_CMD_LEN'(0);
   localparam logic [EXE_CMD_LEN-1:0] CMD_ADD = EXE_CMD_LEN'(1);
   localparam logic [EXE_CMD_LEN-1:0] CMD_SUB = EXE_CMD_LEN'(2);
   localparam logic [EXE_CMD_LEN-1:0] CMD_AND = EXE_CMD_LEN'(3);
   localparam logic [EXE_CMD_LEN-1:0] CMD_OR  = EXE_CMD_LEN'(4);
   localparam logic [EXE_CMD_LEN-1:0] CMD_NOR = EXE_CMD_LEN'(5);
   localparam logic [EXE_CMD_LEN-1:0] CMD_XOR = EXE_CMD_LEN'(6);
   localparam logic [EXE_CMD_LEN-1:0] CMD_SLA = EXE_CMD_LEN'(7);
   localparam logic [EXE_CMD_LEN-1:0] CMD_SLL = EXE_CMD_LEN'(8);
   localparam logic [EXE_CMD_LEN-1:0] CMD_SRA = EXE_CMD_LEN'(9);
   localparam logic [EXE_CMD_LEN-1:0] CMD_SRL = EXE_CMD_LEN'(10);

   logic [WORD_LEN-1:0]          op1, op2, st_fwd, alu_c;
   logic [SHAMT_W-1:0]           shamt;
   logic [WORD_LEN-1:0]          res_c, st_c;
   logic [REG_FILE_ADDR_LEN-1:0] dest_c;
   logic                         mr_c, mw_c, wb_c, bubble_c;

   function automatic logic [WORD_LEN-1:0] fwd_mux(input logic [1:0]          sel,
                                                  input logic [WORD_LEN-1:0] own,
                                                  input logic [WORD_LEN-1:0] mem_v,
                                                  input logic [WORD_LEN-1:0] wb_v);
      case (sel)
         2'd1:    return mem_v;
         2'd2:    return wb_v;
         default: return own;
      endcase
   endfunction

   // Forwarding muxes
   always_comb begin
      op1    = fwd_mux(fwd_sel1, val1, mem_fwd_val, wb_fwd_val);
      op2    = fwd_mux(fwd_sel2, val2, mem_fwd_val, wb_fwd_val);
      st_fwd = fwd_mux(fwd_sel_st, st_value, mem_fwd_val, wb_fwd_val);
      shamt  = op2[SHAMT_W-1:0];
   end

   // Single-cycle ALU; unknown and multi-cycle commands give 0 here
   always_comb begin
      alu_c = '0;
      case (exe_cmd)
         CMD_NOP:          alu_c = '0;
         CMD_ADD:          alu_c = op1 + op2;
         CMD_SUB:          alu_c = op1 - op2;
         CMD_AND:          alu_c = op1 & op2;
         CMD_OR:           alu_c = op1 | op2;
         CMD_NOR:          alu_c = ~(op1 | op2);
         CMD_XOR:          alu_c = op1 ^ op2;
         CMD_SLA, CMD_SLL: alu_c = op1 << shamt;
         CMD_SRA:          alu_c = $unsigned($signed(op1) >>> shamt);
         CMD_SRL:          alu_c = op1 >> shamt;
         default:          alu_c = '0;
      endcase
   end

`ifdef EXE_MULDIV_EN
   localparam int unsigned CNT_W = $clog2(WORD_LEN);
   localparam logic [EXE_CMD_LEN-1:0] CMD_MUL  = EXE_CMD_LEN'(11);
   localparam logic [EXE_CMD_LEN-1:0] CMD_DIVU = EXE_CMD_LEN'(12);
   localparam logic [EXE_CMD_LEN-1:0] CMD_REMU = EXE_CMD_LEN'(13);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t                       state_q, state_d;
   logic [CNT_W-1:0]             cnt_q;
   logic [EXE_CMD_LEN-1:0]       cmd_q;
   // MUL: a_q=multiplicand, b_q=multiplier, acc_q=product.
   // DIV: a_q=dividend shifting into quotient, b_q=divisor, acc_q=remainder.
   logic [WORD_LEN-1:0]          a_q, b_q, acc_q;
   logic [WORD_LEN-1:0]          md_st_q;
   logic [REG_FILE_ADDR_LEN-1:0] md_dest_q;
   logic                         md_mr_q, md_mw_q, md_wb_q;
   logic                         md_cmd_c, div_ge_c;
   logic [WORD_LEN:0]            rem_sh_c;
   logic [WORD_LEN-1:0]          rem_diff_c;

   assign md_cmd_c = (exe_cmd == CMD_MUL) || (exe_cmd == CMD_DIVU) || (exe_cmd == CMD_REMU);

   // Restoring divide step; a zero divisor always subtracts, giving all-ones / dividend
   always_comb begin
      rem_sh_c   = {acc_q, a_q[WORD_LEN-1]};
      div_ge_c   = (rem_sh_c >= {1'b0, b_q});
      rem_diff_c = WORD_LEN'(rem_sh_c - {1'b0, b_q});
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next state and upstream stall; DONE never re-accepts the held command
   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (md_cmd_c) begin
               state_d = S_BUSY;
               stall   = 1'b1;
            end
            S_BUSY: begin
               stall = 1'b1;
               if (cnt_q == CNT_W'(WORD_LEN - 1)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
      if (!rst) stall = 1'b0;
   end

   // Operand latch and one iterative step per BUSY cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         cmd_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         md_st_q   <= '0;
         md_dest_q <= '0;
         md_mr_q   <= 1'b0;
         md_mw_q   <= 1'b0;
         md_wb_q   <= 1'b0;
      end else if (!flush) begin
         case (state_q)
            S_IDLE: if (md_cmd_c) begin
               cnt_q     <= '0;
               cmd_q     <= exe_cmd;
               a_q       <= op1;
               b_q       <= op2;
               acc_q     <= '0;
               md_st_q   <= st_fwd;
               md_dest_q <= dest_in;
               md_mr_q   <= mem_r_en_in;
               md_mw_q   <= mem_w_en_in;
               md_wb_q   <= wb_en_in;
            end
            S_BUSY: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (cmd_q == CMD_MUL) begin
                  if (b_q[0]) acc_q <= acc_q + a_q;
                  a_q <= a_q << 1;
                  b_q <= b_q >> 1;
               end else if (div_ge_c) begin
                  acc_q <= rem_diff_c;
                  a_q   <= {a_q[WORD_LEN-2:0], 1'b1};
               end else begin
                  acc_q <= rem_sh_c[WORD_LEN-1:0];
                  a_q   <= {a_q[WORD_LEN-2:0], 1'b0};
               end
            end
            default: ;
         endcase
      end
   end

   // Output bank source: live instruction, or the finished multi-cycle one
   always_comb begin
      bubble_c = (state_q == S_BUSY) || ((state_q == S_IDLE) && md_cmd_c);
      res_c    = alu_c;
      st_c     = st_fwd;
      dest_c   = dest_in;
      mr_c     = mem_r_en_in;
      mw_c     = mem_w_en_in;
      wb_c     = wb_en_in;
      if (state_q == S_DONE) begin
         res_c  = (cmd_q == CMD_DIVU) ? a_q : acc_q;
         st_c   = md_st_q;
         dest_c = md_dest_q;
         mr_c   = md_mr_q;
         mw_c   = md_mw_q;
         wb_c   = md_wb_q;
      end
   end
`else
   assign stall = 1'b0;

   always_comb begin
      bubble_c = 1'b0;
      res_c    = alu_c;
      st_c     = st_fwd;
      dest_c   = dest_in;
      mr_c     = mem_r_en_in;
      mw_c     = mem_w_en_in;
      wb_c     = wb_en_in;
   end
`endif

   // EXE/MEM bank; a bubble clears the enables and holds the data fields
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_res    <= '0;
         st_val_out <= '0;
         dest_out   <= '0;
         mem_r_en   <= 1'b0;
         mem_w_en   <= 1'b0;
         wb_en      <= 1'b0;
      end else if (flush || bubble_c) begin
         mem_r_en   <= 1'b0;
         mem_w_en   <= 1'b0;
         wb_en      <= 1'b0;
      end else begin
         alu_res    <= res_c;
         st_val_out <= st_c;
         dest_out   <= dest_c;
         mem_r_en   <= mr_c;
         mem_w_en   <= mw_c;
         wb_en      <= wb_c;
      end
   end

endmodule
